// File: rtl/seq_if.sv
// seq_if: control/guess/LED bundle between the game controller and seq_player.
// master = game control side, slave = seq_player.
interface seq_if #(
   parameter int CH     = 4,
   parameter int ADDR_W = 4,
   parameter int BANK_W = 2
);
   logic              start;
   logic [ADDR_W-1:0] len;
   logic [BANK_W-1:0] bank;
   logic              guess_valid;
   logic [CH-1:0]     guess;
   logic [CH-1:0]     leds;
   logic [ADDR_W-1:0] step;
   logic              busy;
   logic              show_done;
   logic              hit;
   logic              miss;
   logic              win;

   modport master (
      output start, len, bank, guess_valid, guess,
      input  leds, step, busy, show_done, hit, miss, win
   );

   modport slave (
      input  start, len, bank, guess_valid, guess,
      output leds, step, busy, show_done, hit, miss, win
   );
endinterface

// File: rtl/seq_player.sv
// seq_player: plays a seeded LFSR sequence on one-hot LEDs, then checks player guesses.
// Optional macro SEQ_NO_REPEAT_EN: bump any symbol that would repeat the previous channel.
//
// state    | meaning
// IDLE     | waiting for start, all outputs quiet
// SHOW_ON  | current step's LED lit, ON_CYC cycles
// SHOW_OFF | dark gap after a lit step, OFF_CYC cycles
// CHECK    | comparing guesses against the replayed sequence
module seq_player #(
   parameter int          CH      = 4,
   parameter int          ADDR_W  = 4,
   parameter int          BANK_W  = 2,
   parameter logic [15:0] SEED    = 16'hACE1,
   parameter int          ON_CYC  = 2,
   parameter int          OFF_CYC = 1
) (
   input logic   clk,
   input logic   reset,
   seq_if.slave  bus
);
   localparam int SYM_W   = $clog2(CH);
   localparam int TMR_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] ON_LD  = TMR_W'(ON_CYC - 1);
   localparam logic [TMR_W-1:0] OFF_LD = TMR_W'(OFF_CYC - 1);

   typedef enum logic [1:0] {IDLE, SHOW_ON, SHOW_OFF, CHECK} state_t;

   state_t            state, state_n;
   logic [15:0]       lfsr, lfsr_n, lfsr_shift, start_seed;
   logic [ADDR_W-1:0] step, step_n, len_l, len_l_n, last_idx;
   logic [BANK_W-1:0] bank_l, bank_l_n;
   logic [TMR_W-1:0]  tmr, tmr_n;
   logic [CH-1:0]     leds, leds_n;
   logic              show_done, show_done_n;
   logic              hit, hit_n, miss, miss_n, win, win_n;
   logic [SYM_W-1:0]  cur_sym, nxt_sym;
   logic              is_last;

   // A zero seed would lock the LFSR, so it is forced to 1.
   function automatic logic [15:0] seed_of(input logic [BANK_W-1:0] b);
      logic [15:0] s;
      s = SEED ^ 16'(b);
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

   assign start_seed = seed_of(bus.bank);
   assign lfsr_shift = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   assign last_idx   = len_l - ADDR_W'(1);
   assign is_last    = (step == last_idx);

`ifdef SEQ_NO_REPEAT_EN
   logic [SYM_W-1:0] prev_sym, cur_raw, nxt_raw;
   logic             prev_vld;

   assign cur_raw = lfsr[SYM_W-1:0];
   assign nxt_raw = lfsr_shift[SYM_W-1:0];
   assign cur_sym = (prev_vld && (cur_raw == prev_sym)) ? cur_raw + SYM_W'(1) : cur_raw;
   assign nxt_sym = (nxt_raw == cur_sym) ? nxt_raw + SYM_W'(1) : nxt_raw;

   // Step 0 never has a predecessor; any forward step records the symbol just emitted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_sym <= '0;
         prev_vld <= 1'b0;
      end else if (step_n == '0) begin
         prev_vld <= 1'b0;
      end else if (step_n != step) begin
         prev_sym <= cur_sym;
         prev_vld <= 1'b1;
      end
   end
`else
   assign cur_sym = lfsr[SYM_W-1:0];
   assign nxt_sym = lfsr_shift[SYM_W-1:0];
`endif

   always_comb begin
      state_n     = state;
      lfsr_n      = lfsr;
      step_n      = step;
      len_l_n     = len_l;
      bank_l_n    = bank_l;
      tmr_n       = tmr;
      leds_n      = leds;
      show_done_n = 1'b0;
      hit_n       = 1'b0;
      miss_n      = 1'b0;
      win_n       = 1'b0;
      case (state)
         IDLE: begin
            leds_n = '0;
            step_n = '0;
            if (bus.start) begin
               len_l_n  = bus.len;
               bank_l_n = bus.bank;
               lfsr_n   = start_seed;
               leds_n   = CH'(1) << start_seed[SYM_W-1:0];
               tmr_n    = ON_LD;
               state_n  = SHOW_ON;
            end
         end
         SHOW_ON: begin
            if (tmr == '0) begin
               leds_n  = '0;
               tmr_n   = OFF_LD;
               state_n = SHOW_OFF;
            end else begin
               tmr_n = tmr - TMR_W'(1);
            end
         end
         SHOW_OFF: begin
            if (tmr != '0) begin
               tmr_n = tmr - TMR_W'(1);
            end else if (is_last) begin
               show_done_n = 1'b1;
               lfsr_n      = seed_of(bank_l);
               step_n      = '0;
               state_n     = CHECK;
            end else begin
               lfsr_n  = lfsr_shift;
               step_n  = step + ADDR_W'(1);
               leds_n  = CH'(1) << nxt_sym;
               tmr_n   = ON_LD;
               state_n = SHOW_ON;
            end
         end
         CHECK: begin
            if (bus.guess_valid) begin
               if (bus.guess == (CH'(1) << cur_sym)) begin
                  hit_n = 1'b1;
                  if (is_last) begin
                     win_n   = 1'b1;
                     step_n  = '0;
                     state_n = IDLE;
                  end else begin
                     lfsr_n = lfsr_shift;
                     step_n = step + ADDR_W'(1);
                  end
               end else begin
                  miss_n  = 1'b1;
                  step_n  = '0;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         lfsr      <= seed_of('0);
         step      <= '0;
         len_l     <= '0;
         bank_l    <= '0;
         tmr       <= '0;
         leds      <= '0;
         show_done <= 1'b0;
         hit       <= 1'b0;
         miss      <= 1'b0;
         win       <= 1'b0;
      end else begin
         state     <= state_n;
         lfsr      <= lfsr_n;
         step      <= step_n;
         len_l     <= len_l_n;
         bank_l    <= bank_l_n;
         tmr       <= tmr_n;
         leds      <= leds_n;
         show_done <= show_done_n;
         hit       <= hit_n;
         miss      <= miss_n;
         win       <= win_n;
      end
   end

   assign bus.leds      = leds;
   assign bus.step      = step;
   assign bus.busy      = (state != IDLE);
   assign bus.show_done = show_done;
   assign bus.hit       = hit;
   assign bus.miss      = miss;
   assign bus.win       = win;
endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: directed scenarios for seq_player with a per-cycle reference model
// on the default instance and a second ON_CYC=1/OFF_CYC=1 instance for full-depth runs.
module tb_seq_player;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seq_if #(.CH(4), .ADDR_W(4), .BANK_W(2)) a_if ();
   seq_if #(.CH(4), .ADDR_W(4), .BANK_W(2)) b_if ();

   seq_player #(.CH(4), .ADDR_W(4), .BANK_W(2), .SEED(16'hACE1), .ON_CYC(2), .OFF_CYC(1))
      dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
   seq_player #(.CH(4), .ADDR_W(4), .BANK_W(2), .SEED(16'hACE1), .ON_CYC(1), .OFF_CYC(1))
      dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

   int n_checks = 0;
   int n_err    = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // LED pattern of step k for a bank, straight from the seed and shift rule.
   function automatic logic [3:0] sym_led(input logic [1:0] b, input int k);
      logic [15:0] s;
      s = 16'hACE1 ^ {14'b0, b};
      if (s == 16'h0000) s = 16'h0001;
      for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      return 4'b0001 << s[1:0];
   endfunction

   typedef struct packed {
      logic [3:0] leds;
      logic [3:0] step;
      logic       busy;
      logic       sd;
   } exp_t;

   exp_t       trace[$];
   logic [3:0] e_leds = '0, e_step = '0;
   logic       e_busy = 1'b0, e_sd = 1'b0, e_hit = 1'b0, e_miss = 1'b0, e_win = 1'b0;

   // Reference for dut_a: playback is a precomputed cycle trace, check phase walks the sequence.
   initial begin : model
      int         mode, cur, m_k, m_len;
      logic [1:0] m_bank;
      exp_t       e;
      mode = 0; m_k = 0; m_len = 1; m_bank = '0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            trace.delete();
            mode = 0; m_k = 0;
            e_leds = '0; e_step = '0; e_busy = 1'b0;
            e_sd = 1'b0; e_hit = 1'b0; e_miss = 1'b0; e_win = 1'b0;
         end else begin
            cur = mode;
            e_sd = 1'b0; e_hit = 1'b0; e_miss = 1'b0; e_win = 1'b0;
            if (cur == 2) begin
               e_leds = '0; e_busy = 1'b1; e_step = 4'(m_k);
               if (a_if.guess_valid) begin
                  if (a_if.guess == sym_led(m_bank, m_k)) begin
                     e_hit = 1'b1;
                     if (m_k == m_len - 1) begin
                        e_win = 1'b1; mode = 0; e_busy = 1'b0; e_step = '0;
                     end else begin
                        m_k++; e_step = 4'(m_k);
                     end
                  end else begin
                     e_miss = 1'b1; mode = 0; e_busy = 1'b0; e_step = '0;
                  end
               end
            end
            if (cur == 0) begin
               e_leds = '0; e_step = '0; e_busy = 1'b0;
               if (a_if.start) begin
                  m_len  = (a_if.len == 4'd0) ? 16 : int'(a_if.len);
                  m_bank = a_if.bank;
                  for (int k = 0; k < m_len; k++) begin
                     for (int c = 0; c < 2; c++) begin
                        e.leds = sym_led(m_bank, k); e.step = 4'(k); e.busy = 1'b1; e.sd = 1'b0;
                        trace.push_back(e);
                     end
                     e.leds = '0; e.step = 4'(k); e.busy = 1'b1; e.sd = 1'b0;
                     trace.push_back(e);
                  end
                  e.leds = '0; e.step = '0; e.busy = 1'b1; e.sd = 1'b1;
                  trace.push_back(e);
                  mode = 1;
               end
            end
            if (mode == 1) begin
               if (trace.size() == 0) begin
                  mode = 0;
               end else begin
                  e = trace.pop_front();
                  e_leds = e.leds; e_step = e.step; e_busy = e.busy; e_sd = e.sd;
                  if (e.sd) begin mode = 2; m_k = 0; end
               end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("a_leds", a_if.leds, e_leds);
            chk("a_step", a_if.step, e_step);
            chk("a_busy", a_if.busy, e_busy);
            chk("a_show_done", a_if.show_done, e_sd);
            chk("a_hit", a_if.hit, e_hit);
            chk("a_miss", a_if.miss, e_miss);
            chk("a_win", a_if.win, e_win);
         end
      end
   end

   task automatic a_start(input logic [3:0] l, input logic [1:0] b);
      @(negedge clk);
      a_if.len = l; a_if.bank = b; a_if.start = 1'b1;
      @(negedge clk);
      a_if.start = 1'b0;
   endtask

   task automatic a_guess(input logic [3:0] g);
      @(negedge clk);
      a_if.guess_valid = 1'b1; a_if.guess = g;
      @(negedge clk);
      a_if.guess_valid = 1'b0;
   endtask

   task automatic a_wait_done(input int max);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (a_if.show_done) seen = 1'b1;
      end
      chk("a_show_done_timeout", 32'(seen), 32'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      logic [23:0] pat1;
      int lit, sd_cyc;
      pat1 = {4'h2, 4'h2, 4'h0, 4'h1, 4'h1, 4'h0};
      a_if.start = 1'b0; a_if.len = '0; a_if.bank = '0; a_if.guess_valid = 1'b0; a_if.guess = '0;
      b_if.start = 1'b0; b_if.len = '0; b_if.bank = '0; b_if.guess_valid = 1'b0; b_if.guess = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_leds", a_if.leds, 4'b0000);
      chk("rst_busy", a_if.busy, 1'b0);
      chk("rst_step", a_if.step, 4'd0);
      reset = 1'b0;

      // Scenario 1: bank 0, len 2 playback timing
      a_start(4'd2, 2'd0);
      chk("s1_leds_c1", a_if.leds, 4'b0010);
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         chk("s1_leds_seq", a_if.leds, 32'(pat1[23-4*i -: 4]));
      end
      @(negedge clk);
      chk("s1_show_done", a_if.show_done, 1'b1);
      chk("s1_busy", a_if.busy, 1'b1);

      // Scenario 2: correct guesses to a win
      a_guess(4'b0010);
      chk("s2_hit0", a_if.hit, 1'b1);
      chk("s2_nowin0", a_if.win, 1'b0);
      a_guess(4'b0001);
      chk("s2_hit1", a_if.hit, 1'b1);
      chk("s2_win", a_if.win, 1'b1);
      @(negedge clk);
      chk("s2_busy_after_win", a_if.busy, 1'b0);

      // Scenario 3: wrong guess at step 0
      a_start(4'd2, 2'd0);
      a_wait_done(50);
      a_guess(4'b0100);
      chk("s3_miss", a_if.miss, 1'b1);
      chk("s3_nohit", a_if.hit, 1'b0);
      @(negedge clk);
      chk("s3_busy", a_if.busy, 1'b0);
      chk("s3_leds", a_if.leds, 4'b0000);

      // Scenario 4: start and guess_valid during playback ignored, then non-one-hot guess held
      a_start(4'd2, 2'd0);
      a_if.start = 1'b1; a_if.guess_valid = 1'b1; a_if.guess = 4'b0010;
      @(negedge clk);
      a_if.start = 1'b0; a_if.guess_valid = 1'b0;
      chk("s4_leds_unaltered", a_if.leds, 4'b0010);
      a_wait_done(50);
      @(negedge clk);
      a_if.guess_valid = 1'b1; a_if.guess = 4'b0011;
      @(negedge clk);
      chk("s4_miss_nonhot", a_if.miss, 1'b1);
      chk("s4_nohit", a_if.hit, 1'b0);
      repeat (2) @(negedge clk);
      a_if.guess_valid = 1'b0;
      chk("s4_idle", a_if.busy, 1'b0);

      // Longer run on bank 3 guessed to a win
      a_start(4'd5, 2'd3);
      a_wait_done(100);
      for (int k = 0; k < 5; k++) begin
         a_guess(sym_led(2'd3, k));
         chk("b3_hit", a_if.hit, 1'b1);
      end
      chk("b3_win", a_if.win, 1'b1);

      // Scenario 6: asynchronous reset mid-SHOW_ON, then identical replay
      a_start(4'd4, 2'd2);
      #2 reset = 1'b1;
      #1;
      chk("s6_async_leds", a_if.leds, 4'b0000);
      chk("s6_async_busy", a_if.busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      a_start(4'd4, 2'd2);
      chk("s6_replay_first", a_if.leds, sym_led(2'd2, 0));
      a_wait_done(100);

      // Scenario 5: dut_b, len 0 (16 steps), bank 1, ON/OFF 1 cycle each
      @(negedge clk);
      b_if.len = 4'd0; b_if.bank = 2'd1; b_if.start = 1'b1;
      @(negedge clk);
      b_if.start = 1'b0;
      chk("s5_first_leds", b_if.leds, 4'b0001);
      lit = 0; sd_cyc = 0;
      for (int c = 1; c <= 60; c++) begin
         if (c > 1) @(negedge clk);
         if (b_if.leds != 4'b0000) begin
            chk("s5_step", b_if.step, 32'(lit));
            chk("s5_leds", b_if.leds, sym_led(2'd1, lit));
            lit++;
         end
         if (b_if.show_done) begin
            sd_cyc = c;
            break;
         end
      end
      chk("s5_lit_count", 32'(lit), 32'd16);
      chk("s5_done_cycle", 32'(sd_cyc), 32'd33);
      for (int k = 0; k < 16; k++) begin
         chk("s5_chk_step", b_if.step, 32'(k));
         @(negedge clk);
         b_if.guess_valid = 1'b1; b_if.guess = sym_led(2'd1, k);
         @(negedge clk);
         b_if.guess_valid = 1'b0;
         chk("s5_hit", b_if.hit, 1'b1);
         chk("s5_win", b_if.win, (k == 15) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      chk("s5_busy_end", b_if.busy, 1'b0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Parametrised successor to the fixed 16-entry one-hot sequence table used by the memory game.
- Replaces that table with a seeded 16-bit LFSR, so any bank, length or channel count is reproducible without storage.
- On a start pulse it plays the sequence on the LED outputs with programmable on/off timing, then enters a check phase.
- In the check phase it compares player guesses against the same sequence and reports hit, miss and win.
- Sits between the game control FSM and the LED/button I/O.

Parameters:
CH, 4, number of channels (one-hot width); power of 2, range 2..16
ADDR_W, 4, step index width; sequence depth DEPTH = 2^ADDR_W
BANK_W, 2, bank select width
SEED, 16'hACE1, base LFSR seed
ON_CYC, 2, cycles each LED is lit during playback (>=1)
OFF_CYC, 1, dark cycles after each lit step (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin playback
len  in  ADDR_W  sequence length; 0 encodes DEPTH
bank  in  BANK_W  sequence bank select
guess_valid  in  1  player guess strobe
guess  in  CH  player guess, one-hot
leds  out  CH  registered one-hot LED drive
step  out  ADDR_W  current step index
busy  out  1  high in any state other than IDLE
show_done  out  1  one-cycle pulse when playback ends
hit  out  1  one-cycle pulse on a correct guess
miss  out  1  one-cycle pulse on a wrong guess
win  out  1  one-cycle pulse when the last step is guessed correctly

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous, active-high (reset). Every register clears on reset.
- Reset values: leds=0, step=0, busy=0, all pulses=0, FSM=IDLE, lfsr=seed.
- Seed: seed = SEED ^ {zero-extended bank}. If the result is 0, 16'h0001 is used instead.
- Length: len and bank are latched when start is accepted.
- LFSR: Fibonacci form, fb = s[0]^s[2]^s[3]^s[5], next = {fb, s[15:1]}.
- Symbols: the symbol for step k is s[log2(CH)-1:0] of the state before shift k; step 0 uses the seed. leds = 1 << symbol.
- FSM states: IDLE, SHOW_ON, SHOW_OFF, CHECK.
  - IDLE: start=1 latches len/bank, loads lfsr=seed, step=0, and moves to SHOW_ON. leds are valid on the next edge, so latency from start is 1 cycle.
  - SHOW_ON: leds = symbol for ON_CYC cycles, then leds=0 and move to SHOW_OFF.
  - SHOW_OFF: leds=0 for OFF_CYC cycles. Then:
    - if step == len-1: pulse show_done, reload lfsr=seed, step=0, go to CHECK;
    - otherwise: shift the lfsr, step+1, go to SHOW_ON.
  - CHECK: leds=0. On guess_valid, compare guess with 1<<symbol. The response appears the cycle after guess_valid.
    - Match and not the last step: pulse hit, shift the lfsr, step+1.
    - Match on step == len-1: pulse hit and win, go to IDLE.
    - Mismatch, including a non-one-hot or zero guess: pulse miss, go to IDLE.
- start is ignored while busy=1.
- guess_valid is ignored outside CHECK.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No pulse is emitted.
- step wraps only through len. When len=0 (DEPTH steps), the final step index is DEPTH-1.
- Two runs with the same bank always produce an identical sequence. A new bank gives a different seed.

Optional Feature:
- Macro: SEQ_NO_REPEAT_EN.
- Defined:
  - if a step's raw symbol equals the previous step's emitted symbol, the emitted symbol is (raw+1) mod CH;
  - the same rule applies in both playback and check, so no channel is ever lit twice in a row;
  - the previous-symbol register resets to an invalid marker at step 0.
- Undefined: the raw LFSR symbol is used unchanged.

Test Plan:
1. Default parameters, SEED=ACE1, bank=0, len=2, pulse start → leds 0010 for 2 cycles, 0000 for 1, 0001 for 2, 0000 for 1, then show_done pulse, busy stays 1.
2. After scenario 1: guess 0010 then 0001 → hit on each, win on the second; busy=0 on the cycle after win.
3. After a replay of scenario 1: guess 0100 at step 0 → miss pulse, no hit, return to IDLE, leds=0.
4. Hold guess=0011 with guess_valid in CHECK → miss (not one-hot). Pulse start during SHOW_ON → ignored, sequence unaltered.
5. len=0, ON_CYC=1, OFF_CYC=1 → exactly 16 lit steps, step counts 0..15, show_done after the 16th dark cycle. bank=1 → seed ACE0, first leds=0001.
6. Assert reset mid-SHOW_ON → leds=0, busy=0 asynchronously. Next start replays from step 0 with an identical sequence.
